reg_file_2r1w: RTL and testbench

- General-purpose register file: 32 entries x 32 bits, two asynchronous read ports (A, B), one synchronous write port (C).
- Sits in the CPU datapath between decode (operand addresses) and writeback (result data).
- Entire array is cleared by an asynchronous active-high reset.

---
 rtl/reg_file_2r1w.sv | 77 +++++++
 tb/tb_reg_file_2r1w.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w
// -------------
// General-purpose register file for the CPU datapath: DEPTH = 2**ADDR_W
// entries of DATA_W bits, two combinational read ports (A, B) and one
// synchronous write port (C). Register 0 is an ordinary register.
//
// Ports
//   clock         in   rising-edge write clock
//   reset         in   asynchronous active-high clear of the whole array
//   addra / dataa in/out  read port A (zero-cycle latency)
//   addrb / datab in/out  read port B (zero-cycle latency)
//   enc           in   write enable for port C
//   addrc / datac in   write port C address / data
//
// Build option
//   REGFILE_WRITE_BYPASS_EN : when defined, a read whose address matches an
//   enabled write in the same cycle returns datac before the edge. When
//   undefined, reads always show the stored value (old value until the edge).

module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dataa,
    input  logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] datab,
    input  logic              enc,
    input  logic [ADDR_W-1:0] addrc,
    input  logic [DATA_W-1:0] datac
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DEPTH-1:0][DATA_W-1:0] mem_d;

    // Next-state: hold everything, overwrite only the addressed entry.
    always_comb begin
        mem_d = mem_q;
        if (enc) begin
            mem_d[addrc] = datac;
        end
    end

    // Reset clears the array immediately and keeps it cleared while high,
    // so writes presented during reset are dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    // Forward the in-flight write to a matching reader. The reset term keeps
    // reads at zero while reset is held even though enc may be high.
    always_comb begin
        dataa = mem_q[addra];
        datab = mem_q[addrb];
        if (!reset && enc && (addra == addrc)) begin
            dataa = datac;
        end
        if (!reset && enc && (addrb == addrc)) begin
            datab = datac;
        end
    end
`else
    // mem_q is already zero throughout reset, so no explicit gating needed.
    assign dataa = mem_q[addra];
    assign datab = mem_q[addrb];
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] addra, addrb, addrc;
    logic [DATA_W-1:0] dataa, datab, datac;
    logic              enc;

    reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .addra(addra), .dataa(dataa),
        .addrb(addrb), .datab(datab),
        .enc(enc), .addrc(addrc), .datac(datac)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: plain array of register contents.
    logic [DATA_W-1:0] model [DEPTH];

    typedef struct {
        bit                port;   // 0 = A, 1 = B
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] exp;
        string             tag;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Expected read value from the architectural rules.
    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        if (reset) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (enc && a == addrc) return datac;
`endif
        return model[a];
    endfunction

    // Issue: push expectations for both ports at the current inputs.
    task automatic check(input string tag);
        exp_t e;
        e.tag = tag;
        e.port = 1'b0; e.addr = addra; e.exp = ref_read(addra); exp_q.push_back(e);
        e.port = 1'b1; e.addr = addrb; e.exp = ref_read(addrb); exp_q.push_back(e);
        -> sample_ev;
        #2;
    endtask

    // Monitor: samples the outputs and drains the scoreboard.
    initial begin
        exp_t e;
        logic [DATA_W-1:0] act;
        forever begin
            @(sample_ev);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = e.port ? datab : dataa;
                n_chk++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s port %s addr %0d: got %h expected %h",
                             e.tag, e.port ? "B" : "A", e.addr, act, e.exp);
                end
            end
        end
    end

    // One clock edge, model updated with the edge's write, back to negedge.
    task automatic tick();
        @(posedge clock);
        if (!reset && enc) model[addrc] = datac;
        @(negedge clock);
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic sweep_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            addra = ADDR_W'(i);
            addrb = ADDR_W'(DEPTH - 1 - i);
            check(tag);
        end
    endtask

    logic [DATA_W-1:0] fill_tab [DEPTH] = '{
        89, 66, 76, 11, 22, 83, 33, 85, 50, 44, 55, 12, 14, 15, 16, 17,
        18, 19, 21, 23, 63, 24, 25, 26, 27, 28, 29, 30, 31, 32, 34, 13 };

    initial begin
        reset = 1'b1; enc = 1'b0; addra = '0; addrb = '0; addrc = '0; datac = '0;
        clear_model();

        // Power-up under reset: everything reads zero.
        @(negedge clock);
        sweep_all("reset_sweep");
        tick();
        reset = 1'b0;
        tick();

        // Fill: each write is also read at the same address before the edge.
        for (int i = 0; i < DEPTH; i++) begin
            enc = 1'b1; addrc = ADDR_W'(i); datac = fill_tab[i];
            addra = ADDR_W'(i); addrb = ADDR_W'((i + 1) % DEPTH);
            check("fill_pre_edge");
            tick();
        end
        enc = 1'b0;

        // Even addresses on A, odd on B.
        for (int i = 0; i < DEPTH; i += 2) begin
            addra = ADDR_W'(i); addrb = ADDR_W'(i + 1);
            check("fill_readback");
        end

        // Disabled write must not touch r5.
        addrc = 5'd5; datac = 32'hDEADBEEF; addra = 5'd5; addrb = 5'd31;
        repeat (3) tick();
        check("enc_low_hold");

        // Collision: read old before the edge, new after.
        enc = 1'b1; addrc = 5'd20; datac = 32'd10; addra = 5'd20; addrb = 5'd20;
        check("collide_pre");
        tick();
        enc = 1'b0;
        check("collide_post");

        // Dual read, then B address change without an edge.
        addra = 5'd7; addrb = 5'd7;
        check("dual_same");
        addrb = 5'd8;
        check("dual_change_b");

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            enc   = 1'($urandom_range(0, 1));
            addrc = ADDR_W'($urandom);
            datac = $urandom;
            addra = ($urandom_range(0, 3) == 0) ? addrc : ADDR_W'($urandom);
            addrb = ($urandom_range(0, 3) == 0) ? addrc : ADDR_W'($urandom);
            check("rand_pre");
            tick();
            check("rand_post");
        end

        // Short reset pulse between edges, with a write pending.
        enc = 1'b0; addra = 5'd7; addrb = 5'd8;
        @(posedge clock);
        #1;
        enc = 1'b1; addrc = 5'd3; datac = 32'hA5A5A5A5;
        reset = 1'b1;
        clear_model();
        check("async_reset_now");
        enc = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        sweep_all("after_pulse_sweep");

        // Reset held across an edge drops the write.
        for (int i = 0; i < 4; i++) begin
            enc = 1'b1; addrc = ADDR_W'(i); datac = 32'h100 + i; tick();
        end
        enc = 1'b1; addrc = 5'd9; datac = 32'h1234; reset = 1'b1;
        clear_model();
        tick();
        enc = 1'b0; addra = 5'd9; addrb = 5'd0;
        check("reset_blocks_write");
        reset = 1'b0;

        // First edge after release writes again.
        enc = 1'b1; addrc = 5'd9; datac = 32'h5678;
        tick();
        enc = 1'b0; addra = 5'd9; addrb = 5'd1;
        check("write_after_reset");

        #5;
        if (exp_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
